// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module   : e_mdu
// Purpose  : E-stage multiply/divide unit owning the HI/LO registers.
//            Optional madd/maddu support is enabled by defining MDU_MADD_EN.
// Revision : 1.0  initial release
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IntReq,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
`endif

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_op;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_mt_ok;

    always_comb begin
        w_is_mul = (MDUop == c_OP_MULT) || (MDUop == c_OP_MULTU);
`ifdef MDU_MADD_EN
        w_is_mul = w_is_mul || (MDUop == c_OP_MADD) || (MDUop == c_OP_MADDU);
`endif
        w_is_div = (MDUop == c_OP_DIV) || (MDUop == c_OP_DIVU);
    end

    assign Start   = (w_is_mul || w_is_div) && !IntReq && !r_busy;
    assign w_mt_ok = !IntReq && !r_busy;

    // Result datapath works only from the shadow operands captured at Start.
    logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_a_sx   = {{32{r_a[31]}}, r_a};
    assign w_b_sx   = {{32{r_b[31]}}, r_b};
    assign w_a_zx   = {32'd0, r_a};
    assign w_b_zx   = {32'd0, r_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;

    // One unsigned divider serves both forms; signed results are fixed up by
    // magnitude, which also yields 0x80000000 for -2^31 / -1 without overflow.
    logic        w_div_signed;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q_out, w_r_out;

    assign w_div_signed = (r_op == c_OP_DIV);
    assign w_a_mag = (w_div_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_b_mag = (w_div_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_q_out = (w_div_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_out = (w_div_signed && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    logic [31:0] w_res_hi, w_res_lo;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            c_OP_DIV, c_OP_DIVU: begin
                if (r_b != 32'd0) begin
                    w_res_hi = w_r_out;
                    w_res_lo = w_q_out;
                end
            end
`ifdef MDU_MADD_EN
            // HI/LO cannot change while busy, so they still hold the Start-time value.
            c_OP_MADD:  {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s;
            c_OP_MADDU: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                        r_op    <= MDUop;
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= w_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
                    end else if (w_mt_ok && (MDUop == c_OP_MTHI)) begin
                        r_hi <= A;
                    end else if (w_mt_ok && (MDUop == c_OP_MTLO)) begin
                        r_lo <= A;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MDUOut = (MDUop == c_OP_MFHI) ? r_hi :
                    (MDUop == c_OP_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of cycles Busy stays high for mult/multu/madd/maddu.
REQ-002 Parameter DIV_CYCLES, default 10, number of cycles Busy stays high for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IntReq  input  1  interrupt/exception flush; the E-stage instruction this cycle is cancelled.
REQ-006 MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu; 11-15 none.
REQ-007 A  input  32  forwarded rs operand from E stage.
REQ-008 B  input  32  forwarded rt operand from E stage.
REQ-009 Start  output  1  combinational: MDUop is a multiply/divide class op and IntReq low, and the unit is not Busy.
REQ-010 Busy  output  1  registered: an operation is in progress; D-stage stall logic uses Start|Busy.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 MDUOut  output  32  combinational: HI when MDUop=7, LO when MDUop=8, else 0.

Function
REQ-014 States IDLE and BUSY; IDLE->BUSY on clock edge where Start=1; BUSY->IDLE on edge where the cycle counter reaches 1.
REQ-015 On Start, counter loads MULT_CYCLES (ops 1,2,9,10) or DIV_CYCLES (ops 3,4); it decrements by 1 each cycle in BUSY.
REQ-016 Op issued in cycle t: Busy high in cycles t+1..t+N exactly; HI/LO take the new result on the edge ending cycle t+N, visible from t+N+1.
REQ-017 Result computed from A/B sampled at Start and held in shadow registers; later A/B changes have no effect.
REQ-018 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit A*B.
REQ-019 div: LO = signed A/B truncated toward zero, HI = signed remainder with sign of A; divu: unsigned quotient/remainder.
REQ-020 div/divu with B=0: Busy sequence runs normally, HI and LO remain unchanged.
REQ-021 mthi/mtlo (5/6): HI or LO := A on the same clock edge, only when IntReq=0 and Busy=0; otherwise ignored.
REQ-022 Any op (1-6, 9, 10) presented while Busy=1 is ignored; the running operation completes unaffected.
REQ-023 IntReq=1 in the issue cycle: op not started, no register changes; IntReq during BUSY does not abort the running operation.
REQ-024 mfhi/mflo while Busy return the pre-operation HI/LO value (D-stage stall guarantees this never occurs architecturally).
REQ-025 Ops 0, 7, 8 and 11-15 never change state.

Reset
REQ-026 reset=1 on a clock edge: HI=0, LO=0, Busy=0, counter=0, state IDLE, shadow registers cleared.
REQ-027 reset mid-operation abandons it; no HI/LO commit occurs at or after the reset edge.
REQ-028 reset takes priority over Start, mthi/mtlo and completion in the same cycle.

Configuration
REQ-029 Macro MDU_MADD_EN defined: madd {HI,LO} := {HI,LO} + signed A*B, maddu {HI,LO} := {HI,LO} + unsigned A*B, modulo 2^64, MULT_CYCLES latency, accumulating onto HI/LO as sampled at Start.
REQ-030 Macro MDU_MADD_EN undefined: MDUop 9 and 10 behave as op 0 (Start=0, no state change).

Verification
REQ-031 mult A=0xFFFFFFFF B=0x00000002 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-032 multu same operands -> HI=0x00000001 LO=0xFFFFFFFE after 5 Busy cycles.
REQ-033 div A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; then divu A=5 B=0 -> HI/LO unchanged after 10 Busy cycles.
REQ-034 mult with IntReq=1 same cycle -> Start=0, Busy never rises, HI/LO unchanged; mthi A=0x1234 with IntReq=1 -> HI unchanged.
REQ-035 mthi A=0xAAAA5555 during BUSY -> ignored, HI equals mult result; reset asserted in 3rd Busy cycle -> next cycle Busy=0, HI=LO=0.
REQ-036 With MDU_MADD_EN, HI=0 LO=0xFFFFFFFF, maddu A=1 B=1 -> after 5 cycles HI=1 LO=0; without it, op 9 leaves HI/LO and Busy unchanged.
